// File: rtl/div_stream_ctrl.sv
// div_stream_ctrl: valid/ready front-end for the pipelined divider.
// Issues tagged operand pairs into the divider, tracks in-flight slots in a
// shadow shift register, and queues quotient+tag in issue order in an output
// FIFO. Issue is credit-gated so the FIFO can never overflow.
module div_stream_ctrl #(
  parameter int DIV_LAT   = 13,
  parameter int OUT_DEPTH = 16,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [12:0]      in_dividend,
  input  logic [12:0]      in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             div_start,
  output logic [12:0]      div_dividend,
  output logic [12:0]      div_divisor,
  input  logic [11:0]      div_quotient,
  input  logic             div_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [11:0]      out_quotient,
  output logic [TAG_W-1:0] out_tag,
  output logic             err
);

  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int ENT_W = 12 + TAG_W;

  logic [DIV_LAT-1:0] sh_v_q, sh_v_d;
  logic [TAG_W-1:0]   sh_tag_q [DIV_LAT];
  logic [TAG_W-1:0]   sh_tag_d [DIV_LAT];
  logic [ENT_W-1:0]   mem_q [OUT_DEPTH];
  logic [ENT_W-1:0]   mem_d [OUT_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic               err_q, err_d;

  logic               in_fire;
  logic               advance;
  logic               capture;
  logic               pop;
  logic [CNT_W:0]     credit_sum;
  logic [ENT_W-1:0]   head;

  // Handshake, credit check and divider drive; bubbles are 0/1 so the divider never sees x/0.
  always_comb begin
    credit_sum   = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
    in_ready     = !rst && (credit_sum < (CNT_W + 1)'(OUT_DEPTH));
    in_fire      = in_valid && in_ready;
    advance      = !rst && (in_fire || (inflight_q != '0));
    capture      = advance && sh_v_q[DIV_LAT-1];
    out_valid    = (fifo_cnt_q != '0);
    pop          = out_valid && out_ready;
    div_start    = advance;
    div_dividend = 13'd0;
    div_divisor  = 13'd0;
    if (!rst) begin
      div_dividend = in_fire ? in_dividend : 13'd0;
      div_divisor  = in_fire ? in_divisor  : 13'd1;
    end
    head         = mem_q[rd_ptr_q];
    out_quotient = head[ENT_W-1:TAG_W];
    out_tag      = head[TAG_W-1:0];
    err          = err_q;
  end

  // Shadow register moves in lockstep with the divider pipeline and freezes with it.
  always_comb begin
    sh_v_d   = sh_v_q;
    sh_tag_d = sh_tag_q;
    if (advance) begin
      sh_v_d[0]   = in_fire;
      sh_tag_d[0] = in_tag;
      for (int i = 1; i < DIV_LAT; i++) begin
        sh_v_d[i]   = sh_v_q[i-1];
        sh_tag_d[i] = sh_tag_q[i-1];
      end
    end
  end

  // Output FIFO, in-flight counter and sticky error next-state.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = inflight_q;
    fifo_cnt_d = fifo_cnt_q;
    err_d      = err_q || (capture && !div_done);
    if (capture) begin
      mem_d[wr_ptr_q] = {div_quotient, sh_tag_q[DIV_LAT-1]};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({in_fire, capture})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
    case ({capture, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // State registers; reset discards everything in flight or queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_v_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < DIV_LAT; i++) sh_tag_q[i] <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sh_v_q     <= sh_v_d;
      sh_tag_q   <= sh_tag_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_div_stream_ctrl.sv
// tb_div_stream_ctrl: randomized scoreboard bench for div_stream_ctrl.
// Expected results (dividend[11:0] ^ divisor[11:0], tag) are queued at every
// accepted operand pair and compared in order whenever a result is popped.
module tb_div_stream_ctrl;

  localparam int DIV_LAT   = 13;
  localparam int OUT_DEPTH = 16;
  localparam int TAG_W     = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [12:0]      in_dividend;
  logic [12:0]      in_divisor;
  logic [TAG_W-1:0] in_tag;
  logic             div_start;
  logic [12:0]      div_dividend;
  logic [12:0]      div_divisor;
  logic [11:0]      div_quotient;
  logic             div_done;
  logic             out_valid;
  logic             out_ready;
  logic [11:0]      out_quotient;
  logic [TAG_W-1:0] out_tag;
  logic             err;

  logic [11:0]      pipe [DIV_LAT];
  logic             done_flag;
  logic             hold_not_done;

  logic [15:0]      exp_q [$];
  int               n_vec  = 0;
  int               n_miss = 0;

  int               lat;
  int               first_seen;
  int               acc;
  int               issued;
  int               cycles;
  bit               found;

  div_stream_ctrl #(
    .DIV_LAT  (DIV_LAT),
    .OUT_DEPTH(OUT_DEPTH),
    .TAG_W    (TAG_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dividend (in_dividend),
    .in_divisor  (in_divisor),
    .in_tag      (in_tag),
    .div_start   (div_start),
    .div_dividend(div_dividend),
    .div_divisor (div_divisor),
    .div_quotient(div_quotient),
    .div_done    (div_done),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_quotient(out_quotient),
    .out_tag     (out_tag),
    .err         (err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Divider stand-in: advance-gated delay line returning the low 12 bits xored.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DIV_LAT; i++) pipe[i] <= '0;
      done_flag <= 1'b0;
    end else if (div_start) begin
      pipe[0] <= div_dividend[11:0] ^ div_divisor[11:0];
      for (int i = 1; i < DIV_LAT; i++) pipe[i] <= pipe[i-1];
      done_flag <= 1'b1;
    end
  end
  assign div_quotient = pipe[DIV_LAT-1];
  assign div_done     = done_flag && !hold_not_done;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Record the expected result of every accepted operand pair; reset flushes the queue.
  always @(negedge clk) begin
    if (rst) exp_q.delete();
    else if (in_valid && in_ready)
      exp_q.push_back({in_dividend[11:0] ^ in_divisor[11:0], in_tag});
  end

  // Compare every popped result against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("[TB] FAIL unexpected_result: actual %0h required none at %0t", {out_quotient, out_tag}, $time);
      end else begin
        check_output("result_order", {16'h0, out_quotient, out_tag}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [12:0] a, input logic [12:0] b,
                                input logic [TAG_W-1:0] t, input logic r);
    in_valid    = v;
    in_dividend = a;
    in_divisor  = b;
    in_tag      = t;
    out_ready   = r;
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    apply_stimulus(1'b0, 13'd0, 13'd0, '0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid && !div_start) begin
        ok = 1'b1;
        break;
      end
    end
    check_output({name, "_drained"}, 32'(ok), 32'd1);
    check_output({name, "_left"}, 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  initial begin
    hold_not_done = 1'b0;
    rst = 1'b1;
    apply_stimulus(1'b0, 13'd0, 13'd0, '0, 1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_in_ready", 32'(in_ready), 32'd0);
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_div_start", 32'(div_start), 32'd0);
    check_output("rst_div_dividend", 32'(div_dividend), 32'd0);
    check_output("rst_div_divisor", 32'(div_divisor), 32'd0);
    check_output("rst_err", 32'(err), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_output("post_rst_in_ready", 32'(in_ready), 32'd1);
    check_output("idle_div_start", 32'(div_start), 32'd0);

    // T1: single operation, fixed latency and value
    tick();
    apply_stimulus(1'b1, 13'h0ABC, 13'h0123, 4'd5, 1'b1);
    @(negedge clk);
    check_output("t1_div_start", 32'(div_start), 32'd1);
    check_output("t1_div_dividend", 32'(div_dividend), 32'h0ABC);
    check_output("t1_div_divisor", 32'(div_divisor), 32'h0123);
    tick();
    apply_stimulus(1'b0, 13'd0, 13'd0, '0, 1'b1);
    lat = 0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check_output("t1_bubble_divisor", 32'(div_divisor), 32'd1);
        check_output("t1_advance_inflight", 32'(div_start), 32'd1);
      end
      if (out_valid) begin
        found = 1'b1;
        break;
      end
    end
    check_output("t1_found", 32'(found), 32'd1);
    check_output("t1_latency", 32'(lat), 32'd14);
    check_output("t1_quotient", 32'(out_quotient), 32'hB9F);
    check_output("t1_tag", 32'(out_tag), 32'd5);
    repeat (5) @(negedge clk);
    check_output("t1_start_drained", 32'(div_start), 32'd0);
    check_output("t1_out_empty", 32'(out_valid), 32'd0);
    check_output("t1_err", 32'(err), 32'd0);
    tick();

    // T2: 20 back-to-back operations with free-flowing output
    first_seen = -1;
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b1, 13'($urandom), 13'($urandom), TAG_W'(i), 1'b1);
      @(negedge clk);
      check_output("t2_in_ready", 32'(in_ready), 32'd1);
      if (out_valid && first_seen < 0) first_seen = i;
      tick();
    end
    check_output("t2_first_out", 32'(first_seen), 32'd14);
    drain("t2");

    // T3: output stalled, credits exhaust at OUT_DEPTH
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(1'b1, 13'($urandom), 13'($urandom), TAG_W'($urandom), 1'b0);
      @(negedge clk);
      if (in_ready) acc++;
      tick();
    end
    check_output("t3_accepted", 32'(acc), 32'(OUT_DEPTH));
    @(negedge clk);
    check_output("t3_in_ready_full", 32'(in_ready), 32'd0);
    check_output("t3_out_valid_full", 32'(out_valid), 32'd1);
    tick();
    apply_stimulus(1'b1, 13'($urandom), 13'($urandom), TAG_W'($urandom), 1'b1);
    @(negedge clk);
    check_output("t3_ready_during_pop", 32'(in_ready), 32'd0);
    tick();
    apply_stimulus(1'b1, 13'($urandom), 13'($urandom), TAG_W'($urandom), 1'b0);
    @(negedge clk);
    check_output("t3_credit_return", 32'(in_ready), 32'd1);
    tick();
    drain("t3");

    // T4: random traffic on both sides
    issued = 0;
    cycles = 0;
    while (issued < 1000 && cycles < 20000) begin
      apply_stimulus(1'($urandom_range(0, 9) < 7), 13'($urandom), 13'($urandom),
                     TAG_W'($urandom), 1'($urandom_range(0, 9) < 6));
      @(negedge clk);
      if (in_valid && in_ready) issued++;
      cycles++;
      tick();
    end
    check_output("t4_issued", 32'(issued), 32'd1000);
    drain("t4");
    check_output("t4_err", 32'(err), 32'd0);

    // T5: reset with 8 in flight and 4 queued
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(1'b1, 13'($urandom), 13'($urandom), TAG_W'($urandom), 1'b0);
      @(negedge clk);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0, 13'd0, 13'd0, '0, 1'b0);
      @(negedge clk);
      tick();
    end
    @(negedge clk);
    check_output("t5_pre_out_valid", 32'(out_valid), 32'd1);
    check_output("t5_pre_div_start", 32'(div_start), 32'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    check_output("t5_out_valid", 32'(out_valid), 32'd0);
    check_output("t5_in_ready", 32'(in_ready), 32'd0);
    check_output("t5_div_start", 32'(div_start), 32'd0);
    tick();
    rst = 1'b0;
    apply_stimulus(1'b0, 13'd0, 13'd0, '0, 1'b1);
    repeat (40) @(negedge clk);
    check_output("t5_no_stale", 32'(out_valid), 32'd0);
    check_output("t5_quiet", 32'(div_start), 32'd0);
    tick();

    // T6: divider never reports done, err becomes sticky
    hold_not_done = 1'b1;
    apply_stimulus(1'b1, 13'($urandom), 13'($urandom), 4'd9, 1'b1);
    @(negedge clk);
    tick();
    apply_stimulus(1'b0, 13'd0, 13'd0, '0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        break;
      end
    end
    check_output("t6_found", 32'(found), 32'd1);
    check_output("t6_err_set", 32'(err), 32'd1);
    repeat (10) @(negedge clk);
    check_output("t6_err_sticky", 32'(err), 32'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;
    hold_not_done = 1'b0;
    @(negedge clk);
    check_output("t6_err_cleared", 32'(err), 32'd0);
    check_output("t6_in_ready", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
